iiitb_rv32i: RTL and testbench

- 32-bit, 5-stage in-order pipelined integer core: IF, ID, EX, MEM, WB.
- Uses a fixed-field instruction format, not standard RV32I encoding.
- One unified word-addressed memory `MEM` holds both instructions and data. Register file is `REG[0:31]`.
- Exposes the current fetch PC and the last write-back value for observation. Top-level block; the bench preloads `REG`/`MEM` hierarchically.

---
 rtl/rv32i_pkg.sv | 92 +++++++++
 rtl/rv32i_alu.sv | 29 ++
 rtl/iiitb_rv32i.sv | 125 ++++++++++++
 tb/tb_iiitb_rv32i.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared opcodes, instruction field helpers and pipeline-register layouts
// for the iiitb_rv32i fixed-field five-stage core.
package rv32i_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [4:0]  regidx_t;

  localparam opcode_t OP_ADD  = 6'd0;
  localparam opcode_t OP_SUB  = 6'd1;
  localparam opcode_t OP_AND  = 6'd2;
  localparam opcode_t OP_OR   = 6'd3;
  localparam opcode_t OP_ADDI = 6'd4;
  localparam opcode_t OP_SUBI = 6'd5;
  localparam opcode_t OP_LW   = 6'd6;
  localparam opcode_t OP_SW   = 6'd7;
  localparam opcode_t OP_BEQZ = 6'd8;
  localparam opcode_t OP_BNEZ = 6'd9;
  localparam opcode_t OP_SLT  = 6'd10;
  localparam opcode_t OP_SLTI = 6'd11;
  localparam opcode_t OP_HLT  = 6'd63;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  localparam word_t NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic  vld;
    word_t ir;
    word_t npc;
  } if_id_t;

  typedef struct packed {
    logic    vld;
    opcode_t op;
    logic    wr;
    regidx_t dst;
    word_t   a;
    word_t   b;
    word_t   imm;
    word_t   npc;
  } id_ex_t;

  typedef struct packed {
    logic    wr;
    logic    ld;
    logic    st;
    regidx_t dst;
    word_t   res;
    word_t   sdata;
  } ex_mem_t;

  typedef struct packed {
    logic    wr;
    regidx_t dst;
    word_t   val;
  } mem_wb_t;

  localparam if_id_t IF_ID_NOP = '{vld: 1'b0, ir: NOP_WORD, npc: 32'd0};

  function automatic opcode_t ir_op(input word_t ir);
    return ir[OP_LSB +: 6];
  endfunction

  function automatic regidx_t ir_rs(input word_t ir);
    return ir[RS_LSB +: 5];
  endfunction

  function automatic regidx_t ir_rt(input word_t ir);
    return ir[RT_LSB +: 5];
  endfunction

  function automatic regidx_t ir_rd(input word_t ir);
    return ir[RD_LSB +: 5];
  endfunction

  function automatic word_t ir_imm(input word_t ir);
    return {{16{ir[15]}}, ir[15:0]};
  endfunction

  function automatic logic is_rtype(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
  endfunction

  function automatic logic writes_reg(input opcode_t op);
    return is_rtype(op) || (op inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW});
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational EX-stage ALU; memory ops and unknown opcodes fall through
// to an add so the effective address comes out of the same unit.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  opcode_t op_i,
  input  word_t   a_i,
  input  word_t   b_i,
  output word_t   y_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      OP_SUB, OP_SUBI: y_o = a_i - b_i;
      OP_AND:          y_o = a_i & b_i;
      OP_OR:           y_o = a_i | b_i;
      OP_SLT, OP_SLTI: y_o = {31'd0, (a_s < b_s)};
      default:         y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/iiitb_rv32i.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB), unified word-addressed memory,
// no forwarding or interlocks; branches resolve in EX and squash two slots.
module iiitb_rv32i
  import rv32i_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] WB_OUT,
  output logic [XLEN-1:0] PC
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] REG [0:31];
  logic [XLEN-1:0] MEM [0:MEM_DEPTH-1];

  if_id_t  if_id_q,  if_id_d;
  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    halt_q,   halt_d;
  word_t   pc_d;

  opcode_t id_op;
  regidx_t id_rs;
  regidx_t id_rt;
  logic    ex_taken;
  word_t   ex_target;
  word_t   ex_b;
  word_t   ex_y;
  logic [AW-1:0] mem_addr;

  // IF: fetch, redirect on a taken branch, freeze once HLT reaches ID
  always_comb begin
    pc_d    = PC + 32'd1;
    halt_d  = halt_q;
    if_id_d = '{vld: 1'b1, ir: MEM[PC[AW-1:0]], npc: PC + 32'd1};
    if (ex_taken) begin
      pc_d    = ex_target;
      if_id_d = IF_ID_NOP;
    end else if (halt_q || (if_id_q.vld && id_op == OP_HLT)) begin
      pc_d    = PC;
      halt_d  = 1'b1;
      if_id_d = IF_ID_NOP;
    end
  end

  // ID: decode and register-file read
  assign id_op = ir_op(if_id_q.ir);
  assign id_rs = ir_rs(if_id_q.ir);
  assign id_rt = ir_rt(if_id_q.ir);

  always_comb begin
    id_ex_d.vld = if_id_q.vld & ~ex_taken;
    id_ex_d.op  = id_op;
    id_ex_d.wr  = id_ex_d.vld & writes_reg(id_op);
    id_ex_d.dst = is_rtype(id_op) ? ir_rd(if_id_q.ir) : id_rt;
    id_ex_d.a   = REG[id_rs];
    id_ex_d.b   = REG[id_rt];
    id_ex_d.imm = ir_imm(if_id_q.ir);
    id_ex_d.npc = if_id_q.npc;
  end

  // EX: ALU, effective address and branch resolution
  assign ex_b      = is_rtype(id_ex_q.op) ? id_ex_q.b : id_ex_q.imm;
  assign ex_target = id_ex_q.npc + id_ex_q.imm;
  assign ex_taken  = id_ex_q.vld &&
                     ((id_ex_q.op == OP_BEQZ && id_ex_q.a == '0) ||
                      (id_ex_q.op == OP_BNEZ && id_ex_q.a != '0));

  rv32i_alu u_alu (
    .op_i (id_ex_q.op),
    .a_i  (id_ex_q.a),
    .b_i  (ex_b),
    .y_o  (ex_y)
  );

  always_comb begin
    ex_mem_d.wr    = id_ex_q.wr;
    ex_mem_d.ld    = id_ex_q.vld && id_ex_q.op == OP_LW;
    ex_mem_d.st    = id_ex_q.vld && id_ex_q.op == OP_SW;
    ex_mem_d.dst   = id_ex_q.dst;
    ex_mem_d.res   = ex_y;
    ex_mem_d.sdata = id_ex_q.b;
  end

  // MEM: single data access per instruction, address wraps to MEM_DEPTH
  assign mem_addr = ex_mem_q.res[AW-1:0];

  always_comb begin
    mem_wb_d.wr  = ex_mem_q.wr;
    mem_wb_d.dst = ex_mem_q.dst;
    mem_wb_d.val = ex_mem_q.ld ? MEM[mem_addr] : ex_mem_q.res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC       <= '0;
      WB_OUT   <= '0;
      halt_q   <= 1'b0;
      if_id_q  <= IF_ID_NOP;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      PC       <= pc_d;
      halt_q   <= halt_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      if (mem_wb_q.wr) WB_OUT <= mem_wb_q.val;
    end
  end

  // WB and store writes; storage is never reset so preloaded state survives
  always @(posedge clk) begin
    if (mem_wb_q.wr) REG[mem_wb_q.dst] <= mem_wb_q.val;
    if (ex_mem_q.st) MEM[mem_addr] <= ex_mem_q.sdata;
  end

endmodule

// File: tb/tb_iiitb_rv32i.sv
// Directed and randomized bench for iiitb_rv32i with an instruction-level
// reference model and a fetch-to-writeback latency of four edges.
module tb_iiitb_rv32i;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] WB_OUT;
  logic [31:0] PC;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] FILL = 32'h3000_0000;
  localparam int N = 40;

  logic [31:0] mreg [32];
  logic [31:0] mmem [1024];
  logic [31:0] pres [N];
  logic        pwr  [N];

  iiitb_rv32i #(.MEM_DEPTH(1024), .XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .WB_OUT (WB_OUT),
    .PC     (PC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1, 5:    return a - b;
      2:       return a & b;
      3:       return a | b;
      10, 11:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  initial begin
    int rops [5];
    int iops [3];
    int kind, op, rs, rt, dst, imm;
    logic [31:0] exp_wb;
    rops = '{0, 1, 2, 3, 10};
    iops = '{4, 5, 11};

    // Directed program from the plan, plus writers at 6/7 that must be squashed
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 32; k++) dut.REG[k] = k;
    for (int a = 0; a < 1024; a++) dut.MEM[a] = FILL;
    dut.MEM[0]  = 32'h0022_2000;
    dut.MEM[1]  = 32'h0443_2800;
    dut.MEM[2]  = 32'h10E6_0001;
    dut.MEM[3]  = 32'h1D09_0001;
    dut.MEM[4]  = 32'h190A_0001;
    dut.MEM[5]  = 32'h2000_0028;
    dut.MEM[6]  = enc_i(4, 0, 20, 16'h0055);
    dut.MEM[7]  = enc_i(7, 0, 21, 100);
    dut.MEM[47] = 32'h01AE_6000;
    check("reset_pc", PC, 32'd0);
    check("reset_wb", WB_OUT, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    ticks(1);
    check("pc_after_first_fetch", PC, 32'd1);
    ticks(3);
    check("wb_before_first_wb", WB_OUT, 32'd0);
    ticks(1);
    check("add_wb", WB_OUT, 32'd3);
    check("add_r4", dut.REG[4], 32'd3);
    ticks(1);
    check("sub_wb", WB_OUT, 32'hFFFF_FFFF);
    ticks(1);
    check("addi_wb", WB_OUT, 32'd8);
    ticks(1);
    check("sw_keeps_wb", WB_OUT, 32'd8);
    check("sw_mem9", dut.MEM[9], 32'd9);
    check("branch_pc_target", PC, 32'd46);
    ticks(1);
    check("lw_wb", WB_OUT, 32'd9);
    check("lw_r10", dut.REG[10], 32'd9);
    check("pc_after_target", PC, 32'd47);
    ticks(5);
    check("target_add_wb", WB_OUT, 32'd27);
    check("target_add_r12", dut.REG[12], 32'd27);
    check("squash_r20", dut.REG[20], 32'd20);
    check("squash_mem100", dut.MEM[100], FILL);

    // Asynchronous reset between edges
    ticks(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", PC, 32'd0);
    check("async_wb", WB_OUT, 32'd0);
    check("async_keeps_r12", dut.REG[12], 32'd27);
    check("async_keeps_r6", dut.REG[6], 32'd8);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(1);
    check("restart_pc", PC, 32'd1);
    ticks(3);
    check("restart_wb_idle", WB_OUT, 32'd0);
    ticks(1);
    check("restart_add_wb", WB_OUT, 32'd3);

    // Wrap-around arithmetic, signed compares and HLT at address 10
    rst_n = 1'b0;
    for (int k = 0; k < 32; k++) dut.REG[k] = k;
    dut.REG[1] = 32'h7FFF_FFFF;
    dut.REG[2] = 32'd1;
    dut.REG[3] = 32'hFFFF_FFFF;
    for (int a = 0; a < 1024; a++) dut.MEM[a] = FILL;
    dut.MEM[0]  = enc_r(0, 1, 2, 4);
    dut.MEM[1]  = enc_r(10, 3, 0, 5);
    dut.MEM[2]  = enc_i(11, 3, 6, 0);
    dut.MEM[3]  = enc_i(5, 2, 7, 5);
    dut.MEM[4]  = enc_r(2, 1, 3, 8);
    dut.MEM[5]  = enc_r(3, 2, 3, 9);
    dut.MEM[10] = 32'hFC00_0000;
    dut.MEM[11] = enc_i(4, 0, 20, 16'h0077);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(5);
    check("add_wrap_wb", WB_OUT, 32'h8000_0000);
    check("add_wrap_r4", dut.REG[4], 32'h8000_0000);
    ticks(1);
    check("slt_neg_wb", WB_OUT, 32'd1);
    ticks(1);
    check("slti_neg_wb", WB_OUT, 32'd1);
    ticks(1);
    check("subi_wb", WB_OUT, 32'hFFFF_FFFC);
    ticks(1);
    check("and_wb", WB_OUT, 32'h7FFF_FFFF);
    ticks(1);
    check("or_wb", WB_OUT, 32'hFFFF_FFFF);
    ticks(1);
    check("hlt_fetch_pc", PC, 32'd11);
    ticks(1);
    check("hlt_hold_pc", PC, 32'd11);
    ticks(10);
    check("hlt_hold_pc_late", PC, 32'd11);
    check("hlt_no_r20", dut.REG[20], 32'd20);
    check("hlt_wb_hold", WB_OUT, 32'hFFFF_FFFF);

    // Random hazard-free program: sources r0..r15, destinations r16..r31
    rst_n = 1'b0;
    mreg[0] = 32'd0;
    for (int k = 1; k < 32; k++) mreg[k] = (k < 16) ? $urandom : k;
    mreg[1] = 32'h8000_0000;
    for (int k = 0; k < 32; k++) dut.REG[k] = mreg[k];
    for (int a = 0; a < 1024; a++) mmem[a] = FILL;
    for (int a = 300; a < 332; a++) mmem[a] = $urandom;
    for (int i = 0; i < N; i++) begin
      kind = $urandom_range(0, 4);
      rs   = $urandom_range(0, 15);
      rt   = $urandom_range(0, 15);
      dst  = $urandom_range(16, 31);
      imm  = $urandom_range(0, 65535);
      pwr[i]  = 1'b0;
      pres[i] = 32'd0;
      case (kind)
        0: begin
          op = rops[$urandom_range(0, 4)];
          mmem[i] = enc_r(op, rs, rt, dst);
          pres[i] = alu_ref(op, mreg[rs], mreg[rt]);
          pwr[i]  = 1'b1;
        end
        1: begin
          op = iops[$urandom_range(0, 2)];
          mmem[i] = enc_i(op, rs, dst, imm);
          pres[i] = alu_ref(op, mreg[rs], 32'($signed(16'(imm))));
          pwr[i]  = 1'b1;
        end
        2: begin
          imm = 300 + $urandom_range(0, 31);
          mmem[i] = enc_i(6, 0, dst, imm);
          pres[i] = mmem[imm];
          pwr[i]  = 1'b1;
        end
        3: begin
          imm = 200 + $urandom_range(0, 31);
          mmem[i] = enc_i(7, 0, rt, imm);
          mmem[imm] = mreg[rt];
        end
        default: begin
          mmem[i] = enc_i($urandom_range(12, 62), rs, rt, imm);
        end
      endcase
      if (pwr[i]) mreg[dst] = pres[i];
    end
    mmem[N] = 32'hFC00_0000;
    for (int a = 0; a < 1024; a++) dut.MEM[a] = mmem[a];
    for (int a = 200; a < 232; a++) mmem[a] = (mmem[a] === FILL) ? FILL : mmem[a];
    @(negedge clk);
    rst_n = 1'b1;
    exp_wb = 32'd0;
    for (int e = 0; e < N + 6; e++) begin
      ticks(1);
      if (e >= 4 && e - 4 < N && pwr[e-4]) exp_wb = pres[e-4];
      check($sformatf("rand_wb_edge%0d", e), WB_OUT, exp_wb);
    end
    ticks(3);
    check("rand_hlt_pc", PC, N + 1);
    for (int k = 16; k < 32; k++) check($sformatf("rand_r%0d", k), dut.REG[k], mreg[k]);
    for (int a = 200; a < 232; a++) check($sformatf("rand_mem%0d", a), dut.MEM[a], mmem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
